// File: rtl/demux_pkg.sv
// Shared definitions for the demux4_stream 1-to-4 stream demultiplexer.
// Optional per-lane transfer counters are enabled with DEMUX4_COUNT_EN.
package demux_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LANES      = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned CNT_W      = 8;

    localparam logic [SEL_W-1:0] LANE00 = 2'b00;
    localparam logic [SEL_W-1:0] LANE01 = 2'b01;
    localparam logic [SEL_W-1:0] LANE10 = 2'b10;
    localparam logic [SEL_W-1:0] LANE11 = 2'b11;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

endpackage

// File: rtl/lane_slice.sv
// 1-entry valid/ready output register slice for one demux lane.
// Transfer counter is built only when DEMUX4_COUNT_EN is defined.
module lane_slice
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    lane_state_e       r_state;
    lane_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    assign w_drain = (r_state == LANE_FULL) && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LANE_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LANE_EMPTY: if (load_i) w_state_nxt = LANE_FULL;
            LANE_FULL:  if (w_drain && !load_i) w_state_nxt = LANE_EMPTY;
            default:    w_state_nxt = LANE_EMPTY;
        endcase
    end

    // Data is only replaced on load; a drain leaves the last word visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
        end else if (load_i) begin
            r_data <= data_i;
        end
    end

    assign valid_o = (r_state == LANE_FULL);
    assign data_o  = r_data;

`ifdef DEMUX4_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_drain) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;
`else
    assign count_o = '0;
`endif

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a register slice per lane.
// DEMUX4_COUNT_EN adds 8-bit per-lane transfer counters on count_o.
module demux4_stream
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  select_i,
    output logic [DATA_W-1:0] data00_o,
    output logic [DATA_W-1:0] data01_o,
    output logic [DATA_W-1:0] data10_o,
    output logic [DATA_W-1:0] data11_o,
    output logic [LANES-1:0]  valid_o,
    input  logic [LANES-1:0]  ready_i,
    output logic [31:0]       count_o
);

    logic [LANES-1:0]  w_load;
    logic [DATA_W-1:0] w_data [LANES];
    logic [CNT_W-1:0]  w_count [LANES];
    logic              w_accept;

    // Only the selected lane gates acceptance; other lanes may be stalled.
    assign ready_o  = !rst_i && (!valid_o[select_i] || ready_i[select_i]);
    assign w_accept = valid_i && ready_o;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        assign w_load[n] = w_accept && (select_i == SEL_W'(n));

        lane_slice #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .load_i (w_load[n]),
            .data_i (data_i),
            .ready_i(ready_i[n]),
            .valid_o(valid_o[n]),
            .data_o (w_data[n]),
            .count_o(w_count[n])
        );

        assign count_o[n*CNT_W +: CNT_W] = w_count[n];
    end

    assign data00_o = w_data[LANE00];
    assign data01_o = w_data[LANE01];
    assign data10_o = w_data[LANE10];
    assign data11_o = w_data[LANE11];

endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- 1-to-4 streaming demultiplexer, the distribution-side counterpart of the 4:1 data selector.
- Takes one 32-bit valid/ready stream plus a 2-bit lane select and delivers each word to one of four output lanes.
- Each lane has a 1-entry output register slice, so a stalled lane never blocks words bound for the other lanes.
- Used to fan results out to four consumers, e.g. write-back or decompression units.

Parameters:
- DATA_W, 32, width of data_i and of every lane data output.
- LANES, 4, number of output lanes; fixed at 4 for this revision (select width 2).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- valid_i  input  1  input word valid.
- ready_o  output  1  block accepts input this cycle.
- data_i  input  DATA_W  input word.
- select_i  input  2  destination lane: 00/01/10/11.
- data00_o  output  DATA_W  lane 0 data.
- data01_o  output  DATA_W  lane 1 data.
- data10_o  output  DATA_W  lane 2 data.
- data11_o  output  DATA_W  lane 3 data.
- valid_o  output  4  per-lane valid; bit n = lane n.
- ready_i  input  4  per-lane consumer ready.
- count_o  output  32  per-lane transfer counters, 4 x 8 bits, lane n at [8n+7:8n]; tied to 0 without DEMUX4_COUNT_EN.

Behaviour:
- Reset (rst_i=1 at clk edge):
  - valid_o=0, data*_o=0, count_o=0.
  - Any held words are discarded, including mid-transfer ones.
  - ready_o is 0 during the reset cycle.
- Handshakes:
  - Input transfer when valid_i && ready_o.
  - Lane n transfer when valid_o[n] && ready_i[n].
- ready_o = !rst_i && (!valid_o[select_i] || ready_i[select_i]).
  - Combinational dependence on select_i and ready_i is intended.
  - ready_o depends only on the selected lane; other lanes are ignored.
- On an input transfer to lane s: at the next edge, data_s <= data_i and valid_o[s] <= 1.
  - Latency is 1 cycle from input acceptance to lane valid.
- Lane n register update:
  - Lane transfer with no new load: valid_o[n] <= 0; data holds its last value (no clear).
  - Simultaneous lane drain and new load into the same lane: valid_o[n] stays 1, data replaced. This gives 1 word/cycle throughput per lane.
- Lane slices are independent.
  - Per lane, order is preserved.
  - Across lanes there is no ordering guarantee.
- Input protocol rules:
  - While valid_i && !ready_o, the source holds data_i and select_i stable.
  - The block does not check this rule; behaviour under violation is the same as for a fresh request.
- Once valid_o[n]=1, data_n holds stable until that lane transfers (standard valid/ready).
- Lane state per slice: EMPTY (valid=0) and FULL (valid=1).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain+load, or on no drain.
- valid_i=0: no state change besides lane drains. select_i is don't-care.

Optional Feature:
- Macro DEMUX4_COUNT_EN.
- Defined:
  - Per-lane 8-bit counter increments on each lane output transfer.
  - Counter wraps 255 -> 0.
  - Cleared by rst_i only.
  - Value visible on count_o the cycle after the transfer.
- Undefined: count_o is constant 0 and no counter flops are generated.

Decomposition:
- Shared package demux_pkg:
  - DATA_W default.
  - Lane index constants LANE00..LANE11 (2'b00..2'b11).
  - CNT_W=8.
- One natural sub-module: lane_slice. It is the 1-entry valid/ready register slice with optional counter, instantiated 4 times.
- The top module holds the select decode and the ready_o mux.

Test Plan:
- Reset release, ready_i=4'hF, send 0xAAAA0001 sel=10 -> next cycle valid_o=4'b0100, data10_o=0xAAAA0001, ready_o stays 1.
- Back-to-back burst 0x10..0x13 to sel=01 with ready_i[1]=1 -> one word per cycle on data01_o in order, ready_o never drops.
- ready_i=0; send 0x5 to lane 0, then offer 0x6 to lane 0 -> ready_o=0 and 0x5 held. Offer 0x7 to lane 3 instead -> accepted, valid_o=4'b1001.
- Lane 2 full and stalled, raise ready_i[2] while offering 0x99 to lane 2 -> same-cycle drain+load, valid_o[2] stays 1, data10_o=0x99.
- Assert rst_i with all four lanes full -> next cycle valid_o=0, data*_o=0, count_o=0, ready_o=0 during reset.
- With DEMUX4_COUNT_EN: 257 transfers on lane 1 -> count_o[15:8]=1, other lanes 0. Without the macro -> count_o=0 throughout.
